// File: rtl/fake_n64_console_rx.sv
// Joybus console-command receiver: decodes the console byte stream and hands the line to the controller transmitter after the stop bit.
// Ports: sample_clk and reset (asynchronous, active-high).
//   cur_operation: 0 = receive, 1 = hold idle. data_rx: raw line.
//   Outputs: cmd/cmd_valid, rx_byte/rx_byte_valid, tx_handoff, rx_error.
// Optional: define JOYBUS_RX_TIMEOUT_EN to abort a frame when the line stays high for 2*BIT_WIDTH cycles between bits.
module fake_n64_console_rx #(
  parameter int LEVEL_WIDTH = 2
) (
  input  logic       sample_clk,
  input  logic       reset,
  input  logic       cur_operation,
  input  logic       data_rx,
  output logic [7:0] cmd,
  output logic       cmd_valid,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic       tx_handoff,
  output logic       rx_error
);

  localparam int BIT_WIDTH = 4 * LEVEL_WIDTH;
  localparam int SAMPLE_AT = 2 * LEVEL_WIDTH;
  localparam int TIMEOUT   = 2 * BIT_WIDTH;
  localparam int TW        = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    BIT,
    WAIT_EDGE,
    HANDOFF
  } state_t;

  state_t        state;
  logic          sync1;
  logic          sync2;
  logic          prev;
  logic          fall;
  logic [TW-1:0] bit_timer;
  logic [8:0]    bit_cnt;
  logic [8:0]    exp_bits;
  logic [6:0]    shreg;
  logic [7:0]    new_byte;

  assign fall     = prev & ~sync2;
  assign new_byte = {shreg, sync2};

  // Data-bit count implied by the command byte. The first byte is
  // always 8 bits, so the stale cmd from a previous frame is harmless
  // while byte 0 is still arriving.
  always_comb begin
    exp_bits = 9'd8;
    case (cmd)
      8'h02:   exp_bits = 9'd24;
      8'h03:   exp_bits = 9'd280;
      default: exp_bits = 9'd8;
    endcase
  end

  always_ff @(posedge sample_clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      sync1         <= 1'b1;
      sync2         <= 1'b1;
      prev          <= 1'b1;
      bit_timer     <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      cmd           <= '0;
      cmd_valid     <= 1'b0;
      rx_byte       <= '0;
      rx_byte_valid <= 1'b0;
      tx_handoff    <= 1'b0;
      rx_error      <= 1'b0;
    end else begin
      sync1         <= data_rx;
      sync2         <= sync1;
      prev          <= sync2;
      cmd_valid     <= 1'b0;
      rx_byte_valid <= 1'b0;
      tx_handoff    <= 1'b0;
      rx_error      <= 1'b0;
      if (cur_operation) begin
        state     <= IDLE;
        bit_timer <= '0;
        bit_cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (fall) begin
              state     <= BIT;
              bit_timer <= '0;
              bit_cnt   <= '0;
            end
          end
          BIT: begin
            if (bit_timer == TW'(SAMPLE_AT)) begin
              bit_cnt   <= bit_cnt + 9'd1;
              bit_timer <= '0;
              if (bit_cnt == exp_bits) begin
                // Stop bit: a released line hands over to the transmitter.
                if (sync2) begin
                  state      <= HANDOFF;
                  tx_handoff <= 1'b1;
                end else begin
                  state    <= IDLE;
                  rx_error <= 1'b1;
                end
              end else begin
                state <= WAIT_EDGE;
                shreg <= new_byte[6:0];
                if (bit_cnt[2:0] == 3'd7) begin
                  rx_byte       <= new_byte;
                  rx_byte_valid <= 1'b1;
                  if (bit_cnt == 9'd7) begin
                    cmd       <= new_byte;
                    cmd_valid <= 1'b1;
                  end
                end
              end
            end else begin
              bit_timer <= bit_timer + TW'(1);
            end
          end
          WAIT_EDGE: begin
            if (fall) begin
              state     <= BIT;
              bit_timer <= '0;
            end
`ifdef JOYBUS_RX_TIMEOUT_EN
            // bit_timer doubles as the run length of high samples here.
            else if (sync2) begin
              if (bit_timer == TW'(TIMEOUT - 1)) begin
                state     <= IDLE;
                bit_timer <= '0;
                bit_cnt   <= '0;
                rx_error  <= 1'b1;
              end else begin
                bit_timer <= bit_timer + TW'(1);
              end
            end else begin
              bit_timer <= '0;
            end
`endif
          end
          HANDOFF: begin
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fake_n64_console_rx.sv
// Self-checking bench for fake_n64_console_rx.
// Frames are built from byte lists and checked against a frame-level model.
module tb_fake_n64_console_rx;
  localparam int LW = 2;

  logic       sample_clk = 1'b0;
  logic       reset;
  logic       cur_operation;
  logic       data_rx;
  logic [7:0] cmd;
  logic       cmd_valid;
  logic [7:0] rx_byte;
  logic       rx_byte_valid;
  logic       tx_handoff;
  logic       rx_error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] got_q[$];
  int cmd_cnt   = 0;
  int hand_cnt  = 0;
  int err_cnt   = 0;
  int align_bad = 0;

  always #5 sample_clk = ~sample_clk;

  fake_n64_console_rx #(.LEVEL_WIDTH(LW)) dut (
    .sample_clk(sample_clk),
    .reset(reset),
    .cur_operation(cur_operation),
    .data_rx(data_rx),
    .cmd(cmd),
    .cmd_valid(cmd_valid),
    .rx_byte(rx_byte),
    .rx_byte_valid(rx_byte_valid),
    .tx_handoff(tx_handoff),
    .rx_error(rx_error)
  );

  always @(negedge sample_clk) begin
    if (rx_byte_valid) got_q.push_back(rx_byte);
    if (cmd_valid) begin
      cmd_cnt++;
      if (!rx_byte_valid) align_bad++;
    end
    if (tx_handoff) hand_cnt++;
    if (rx_error) err_cnt++;
  end

  // Frame-level model: number of data bits implied by the command.
  function automatic int n_data_bits(logic [7:0] c);
    case (c)
      8'h02:   return 24;
      8'h03:   return 280;
      default: return 8;
    endcase
  endfunction

  task automatic tick(int n);
    repeat (n) @(negedge sample_clk);
  endtask

  task automatic send_bit(bit b, int gap);
    data_rx = 1'b0;
    tick(b ? LW : 3 * LW);
    data_rx = 1'b1;
    tick((b ? 3 * LW : LW) + gap);
  endtask

  task automatic send_byte(logic [7:0] v, bit jitter);
    for (int i = 7; i >= 0; i--)
      send_bit(v[i], jitter ? int'($urandom_range(0, 3)) : 0);
  endtask

  task automatic expect_quiet(string name, int q0, int c0, int h0, int e0);
    n_checks++;
    if (got_q.size() != q0 || cmd_cnt != c0 || hand_cnt != h0 ||
        err_cnt != e0) begin
      n_fail++;
      $display("FAIL %s: pulses bytes=%0d cmd=%0d hand=%0d err=%0d, required none",
               name, got_q.size() - q0, cmd_cnt - c0, hand_cnt - h0,
               err_cnt - e0);
    end
  endtask

  task automatic run_frame(string name, logic [7:0] c, bit stop, bit jitter,
                           bit use_addr, logic [15:0] addr);
    logic [7:0] exp_q[$];
    int nb = n_data_bits(c) / 8;
    int q0 = got_q.size();
    int c0 = cmd_cnt;
    int h0 = hand_cnt;
    int e0 = err_cnt;
    int a0 = align_bad;
    exp_q.push_back(c);
    for (int k = 1; k < nb; k++) begin
      if (use_addr && k == 1) exp_q.push_back(addr[15:8]);
      else if (use_addr && k == 2) exp_q.push_back(addr[7:0]);
      else exp_q.push_back(8'($urandom));
    end
    foreach (exp_q[k]) send_byte(exp_q[k], jitter);
    send_bit(stop, 0);
    data_rx = 1'b1;
    tick(12);
    n_checks++;
    if (got_q.size() - q0 != nb) begin
      n_fail++;
      $display("FAIL %s byte_count: got %0d required %0d",
               name, got_q.size() - q0, nb);
    end
    for (int k = 0; k < nb; k++) begin
      if (q0 + k < got_q.size()) begin
        n_checks++;
        if (got_q[q0 + k] !== exp_q[k]) begin
          n_fail++;
          $display("FAIL %s byte%0d: got %02h required %02h",
                   name, k, got_q[q0 + k], exp_q[k]);
        end
      end
    end
    n_checks++;
    if (cmd !== c) begin
      n_fail++;
      $display("FAIL %s cmd: got %02h required %02h", name, cmd, c);
    end
    n_checks++;
    if (cmd_cnt - c0 != 1 || align_bad != a0) begin
      n_fail++;
      $display("FAIL %s cmd_valid: got %0d pulses (%0d misaligned) required 1",
               name, cmd_cnt - c0, align_bad - a0);
    end
    n_checks++;
    if (hand_cnt - h0 != int'(stop)) begin
      n_fail++;
      $display("FAIL %s tx_handoff: got %0d required %0d",
               name, hand_cnt - h0, int'(stop));
    end
    n_checks++;
    if (err_cnt - e0 != int'(!stop)) begin
      n_fail++;
      $display("FAIL %s rx_error: got %0d required %0d",
               name, err_cnt - e0, int'(!stop));
    end
  endtask

  task automatic check_reset_outputs(string name);
    n_checks++;
    if (cmd !== 8'h00 || rx_byte !== 8'h00) begin
      n_fail++;
      $display("FAIL %s regs: cmd=%02h rx_byte=%02h required 00 00",
               name, cmd, rx_byte);
    end
    n_checks++;
    if ({cmd_valid, rx_byte_valid, tx_handoff, rx_error} !== 4'b0) begin
      n_fail++;
      $display("FAIL %s pulses: got %b required 0000", name,
               {cmd_valid, rx_byte_valid, tx_handoff, rx_error});
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    cur_operation = 1'b0;
    data_rx = 1'b1;
    tick(3);
    check_reset_outputs("reset");
    reset = 1'b0;
    tick(5);
    check_reset_outputs("post_reset_idle");
  endtask

  task automatic test_directed;
    run_frame("cmd01", 8'h01, 1'b1, 1'b0, 1'b0, 16'h0);
    run_frame("cmd02_addr", 8'h02, 1'b1, 1'b0, 1'b1, 16'h8001);
    run_frame("cmdff_badstop", 8'hFF, 1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic test_abort;
    int q0 = got_q.size();
    int c0 = cmd_cnt;
    int h0 = hand_cnt;
    int e0 = err_cnt;
    for (int i = 0; i < 4; i++) send_bit(1'b0, 0);
    cur_operation = 1'b1;
    tick(4);
    send_byte(8'h00, 1'b0);
    send_bit(1'b1, 0);
    tick(10);
    cur_operation = 1'b0;
    tick(10);
    expect_quiet("abort", q0, c0, h0, e0);
    run_frame("after_abort", 8'h00, 1'b1, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic test_timeout;
    int q0 = got_q.size();
    int c0 = cmd_cnt;
    int h0 = hand_cnt;
    int e0 = err_cnt;
    int exp_err;
`ifdef JOYBUS_RX_TIMEOUT_EN
    exp_err = 1;
`else
    exp_err = 0;
`endif
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    data_rx = 1'b1;
    tick(32);
    n_checks++;
    if (err_cnt - e0 != exp_err) begin
      n_fail++;
      $display("FAIL timeout rx_error: got %0d required %0d",
               err_cnt - e0, exp_err);
    end
    expect_quiet("timeout_other", q0, c0, h0, err_cnt);
    cur_operation = 1'b1;
    tick(2);
    cur_operation = 1'b0;
    tick(4);
  endtask

  task automatic test_reset_midframe;
    int q0;
    int c0;
    int h0;
    int e0;
    send_byte(8'h03, 1'b0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    data_rx = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
    check_reset_outputs("reset_midframe");
    data_rx = 1'b1;
    tick(3);
    reset = 1'b0;
    q0 = got_q.size();
    c0 = cmd_cnt;
    h0 = hand_cnt;
    e0 = err_cnt;
    tick(20);
    expect_quiet("after_reset_quiet", q0, c0, h0, e0);
    run_frame("after_reset", 8'h00, 1'b1, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic test_random;
    logic [7:0] c;
    for (int f = 0; f < 10; f++) begin
      case ($urandom_range(0, 5))
        0: c = 8'h00;
        1: c = 8'hFF;
        2: c = 8'h01;
        3: c = 8'h02;
        4: c = 8'h03;
        default: c = 8'($urandom_range(4, 254));
      endcase
      run_frame($sformatf("rand%0d", f), c, $urandom_range(0, 3) != 0,
                1'b1, 1'b0, 16'h0);
      tick(int'($urandom_range(0, 5)));
    end
  endtask

  task automatic test_back_to_back;
    run_frame("b2b_a", 8'h01, 1'b1, 1'b0, 1'b0, 16'h0);
    run_frame("b2b_b", 8'h02, 1'b1, 1'b1, 1'b0, 16'h0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_abort();
    test_timeout();
    test_reset_midframe();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fake_n64_console_rx.md
FAKE_N64_CONSOLE_RX -- requirements
Module: fake_n64_console_rx

Interface
REQ-001 SHALL have parameter LEVEL_WIDTH, default 2, meaning sample_clk cycles per Joybus level; BIT_WIDTH = 4*LEVEL_WIDTH.
REQ-002 SHALL have port sample_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port cur_operation  input  1  0 = Rx (block active), 1 = Tx (block held idle).
REQ-005 SHALL have port data_rx  input  1  raw Joybus line (1 = high/released, 0 = low).
REQ-006 SHALL have port cmd  output  8  first received byte of the current frame.
REQ-007 SHALL have port cmd_valid  output  1  one-cycle pulse when cmd updates.
REQ-008 SHALL have port rx_byte  output  8  most recently completed byte, MSB first on wire.
REQ-009 SHALL have port rx_byte_valid  output  1  one-cycle pulse per completed byte.
REQ-010 SHALL have port tx_handoff  output  1  one-cycle pulse after a valid stop bit; requests the controller transmitter.
REQ-011 SHALL have port rx_error  output  1  one-cycle pulse on framing error or timeout.

Function
REQ-012 SHALL pass data_rx through a 2-flop synchronizer (both flops reset to 1); all decoding uses the synchronized value.
REQ-013 SHALL implement states IDLE, BIT, WAIT_EDGE, HANDOFF.
REQ-014 IDLE: on synchronized falling edge with cur_operation=0 -> BIT; bit_timer=0, bit_cnt=0.
REQ-015 BIT: bit_timer increments each cycle; at bit_timer==2*LEVEL_WIDTH sample the line (low = 0, high = 1), shift into byte register, increment bit_cnt, go to WAIT_EDGE.
REQ-016 WAIT_EDGE: on next falling edge -> BIT with bit_timer=0 (per-bit resynchronization).
REQ-017 Expected data bits from cmd: 0x00, 0xFF, 0x01 -> 8; 0x02 -> 24; 0x03 -> 280; any other -> 8.
REQ-018 Bit after the last expected data bit is the stop bit; sampled 1 -> HANDOFF; sampled 0 -> rx_error pulse, IDLE.
REQ-019 HANDOFF: tx_handoff=1 for exactly one cycle, then IDLE.
REQ-020 Every 8th data bit: rx_byte and rx_byte_valid pulse on the cycle after the sample; for byte 0, cmd and cmd_valid pulse on the same cycle.
REQ-021 bit_cnt SHALL be 9 bits wide and never wrap (max 281 incl. stop).
REQ-022 cur_operation rising to 1 in any state SHALL force IDLE next cycle, clear counters, no pulses emitted.
REQ-023 All pulse outputs SHALL be registered; no output combinationally depends on data_rx.

Reset
REQ-024 Reset SHALL force IDLE, bit_timer=0, bit_cnt=0, cmd=0x00, rx_byte=0x00, all pulse outputs 0, synchronizer flops 1.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; no pulses until a new falling edge after deassertion.

Configuration
REQ-026 Macro JOYBUS_RX_TIMEOUT_EN defined: in WAIT_EDGE, line high for 2*BIT_WIDTH consecutive cycles -> rx_error pulse, IDLE.
REQ-027 Macro JOYBUS_RX_TIMEOUT_EN undefined: WAIT_EDGE waits indefinitely; rx_error only from REQ-018.

Verification (LEVEL_WIDTH=2)
REQ-028 Send 0x01 (bits LHHH/LLLH, 8 cycles each) + stop 1 -> cmd=0x01, cmd_valid and rx_byte_valid once, tx_handoff once after stop.
REQ-029 Send 0x02, addr 0x8001, stop -> rx_byte 0x02, 0x80, 0x01 in order, tx_handoff once after 25th bit.
REQ-030 Send 0xFF then stop bit encoded as 0 -> cmd=0xFF, rx_error one pulse, no tx_handoff.
REQ-031 Raise cur_operation after 4 bits of 0x00 -> no pulses; subsequent 0x00 frame decodes normally.
REQ-032 With JOYBUS_RX_TIMEOUT_EN: send 3 bits then hold line high 32 cycles -> rx_error one pulse, IDLE; without macro: no pulse.
REQ-033 Assert reset mid-byte of 0x03 frame -> all outputs at reset values; next frame 0x00 decodes correctly.
